// File: rtl/updown_wrap_tracker_if.sv
// Bus between an up/down counter's sampling side and the wrap tracker.
// The master drives the count samples; the slave returns the extended position and status.
interface updown_wrap_tracker_if #(
    parameter int EXT_W = 4,
    parameter int ERR_W = 8
);
    logic [3:0]       cnt_in;
    logic             dir;
    logic             valid;
    logic             resync;
    logic [EXT_W+3:0] ext_count;
    logic             wrap_up;
    logic             wrap_dn;
    logic             step_err;
    logic             dir_err;
    logic             ext_ovf;
    logic [ERR_W-1:0] err_count;
    logic             locked;

    modport master (
        output cnt_in, dir, valid, resync,
        input  ext_count, wrap_up, wrap_dn, step_err, dir_err, ext_ovf, err_count, locked
    );

    modport slave (
        input  cnt_in, dir, valid, resync,
        output ext_count, wrap_up, wrap_dn, step_err, dir_err, ext_ovf, err_count, locked
    );
endinterface

// File: rtl/updown_wrap_tracker.sv
// Extends a wrapping 4-bit up/down count into an EXT_W+4 bit position by counting wraps,
// and flags illegal steps and direction mismatches with a saturating error tally.
module updown_wrap_tracker #(
    parameter int EXT_W = 4,
    parameter int ERR_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    updown_wrap_tracker_if.slave bus
);
    typedef enum logic {ST_INIT, ST_TRACK} state_t;

    state_t           state_reg, state_next;
    logic [EXT_W-1:0] epoch_reg, epoch_next;
    logic [3:0]       prev_reg, prev_next;
    logic             wrap_up_reg, wrap_up_next;
    logic             wrap_dn_reg, wrap_dn_next;
    logic             step_err_reg, step_err_next;
    logic             dir_err_reg, dir_err_next;
    logic             ovf_reg, ovf_next;
    logic [ERR_W-1:0] err_count_reg, err_count_next;
    logic [3:0]       delta;

    // Modulo-16 difference falls out of the 4-bit subtraction
    assign delta = bus.cnt_in - prev_reg;

    always_comb begin
        state_next     = state_reg;
        epoch_next     = epoch_reg;
        prev_next      = prev_reg;
        ovf_next       = ovf_reg;
        err_count_next = err_count_reg;
        wrap_up_next   = 1'b0;
        wrap_dn_next   = 1'b0;
        step_err_next  = 1'b0;
        dir_err_next   = 1'b0;

        if (bus.resync) begin
            state_next = ST_INIT;
        end else if (bus.valid) begin
            prev_next = bus.cnt_in;
            if (state_reg == ST_INIT) begin
                epoch_next = '0;
                state_next = ST_TRACK;
            end else begin
                case (delta)
                    4'd0: ;
                    4'd1: begin
                        dir_err_next = bus.dir;
                        if (prev_reg == 4'd15) begin
                            wrap_up_next = 1'b1;
                            epoch_next   = epoch_reg + 1'b1;
                            if (epoch_reg == '1)
                                ovf_next = 1'b1;
                        end
                    end
                    4'd15: begin
                        dir_err_next = ~bus.dir;
                        if (prev_reg == 4'd0) begin
                            wrap_dn_next = 1'b1;
                            epoch_next   = epoch_reg - 1'b1;
                            if (epoch_reg == '0)
                                ovf_next = 1'b1;
                        end
                    end
                    default: step_err_next = 1'b1;
                endcase
            end
        end

        // At most one error kind fires per sample; the tally sticks at full scale
        if ((step_err_next || dir_err_next) && (err_count_reg != '1))
            err_count_next = err_count_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_INIT;
            epoch_reg     <= '0;
            prev_reg      <= '0;
            wrap_up_reg   <= 1'b0;
            wrap_dn_reg   <= 1'b0;
            step_err_reg  <= 1'b0;
            dir_err_reg   <= 1'b0;
            ovf_reg       <= 1'b0;
            err_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            epoch_reg     <= epoch_next;
            prev_reg      <= prev_next;
            wrap_up_reg   <= wrap_up_next;
            wrap_dn_reg   <= wrap_dn_next;
            step_err_reg  <= step_err_next;
            dir_err_reg   <= dir_err_next;
            ovf_reg       <= ovf_next;
            err_count_reg <= err_count_next;
        end
    end

    assign bus.ext_count = {epoch_reg, prev_reg};
    assign bus.wrap_up   = wrap_up_reg;
    assign bus.wrap_dn   = wrap_dn_reg;
    assign bus.step_err  = step_err_reg;
    assign bus.dir_err   = dir_err_reg;
    assign bus.ext_ovf   = ovf_reg;
    assign bus.err_count = err_count_reg;
    assign bus.locked    = (state_reg == ST_TRACK);
endmodule

// File: tb/tb_updown_wrap_tracker.sv
// Directed bench for updown_wrap_tracker: a position-arithmetic model checked every cycle,
// plus literal expectations; a second instance with a 2-bit error counter covers saturation.
module tb_updown_wrap_tracker;
    localparam int EXT_W = 4;
    localparam int POS_SPAN = 2 ** (EXT_W + 4);

    logic       clk;
    logic       reset;
    logic       rsync;
    logic       vld;
    logic [3:0] cnt;
    logic       dr;

    updown_wrap_tracker_if #(.EXT_W(EXT_W), .ERR_W(8)) bus ();
    updown_wrap_tracker_if #(.EXT_W(EXT_W), .ERR_W(2)) bus2 ();

    assign bus.cnt_in  = cnt;
    assign bus.dir     = dr;
    assign bus.valid   = vld;
    assign bus.resync  = rsync;
    assign bus2.cnt_in = cnt;
    assign bus2.dir    = dr;
    assign bus2.valid  = vld;
    assign bus2.resync = rsync;

    updown_wrap_tracker #(.EXT_W(EXT_W), .ERR_W(8)) dut  (.clk(clk), .reset(reset), .bus(bus));
    updown_wrap_tracker #(.EXT_W(EXT_W), .ERR_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Model: the extended count is just a position on a 0..POS_SPAN-1 ring
    int m_pos, m_errs;
    bit m_locked, m_ovf, m_wu, m_wd, m_se, m_de;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int d;
        if (reset) begin
            m_pos = 0; m_errs = 0; m_locked = 0; m_ovf = 0;
            m_wu = 0; m_wd = 0; m_se = 0; m_de = 0;
        end else begin
            m_wu = 0; m_wd = 0; m_se = 0; m_de = 0;
            if (rsync) begin
                m_locked = 0;
            end else if (vld) begin
                if (!m_locked) begin
                    m_pos = int'(cnt);
                    m_locked = 1;
                end else begin
                    d = (int'(cnt) - (m_pos % 16) + 16) % 16;
                    if (d == 1) begin
                        if (dr) begin m_de = 1; m_errs++; end
                        m_pos = m_pos + 1;
                        if (m_pos % 16 == 0) m_wu = 1;
                        if (m_pos == POS_SPAN) begin m_pos = 0; m_ovf = 1; end
                    end else if (d == 15) begin
                        if (!dr) begin m_de = 1; m_errs++; end
                        if (m_pos % 16 == 0) m_wd = 1;
                        m_pos = m_pos - 1;
                        if (m_pos < 0) begin m_pos = POS_SPAN - 1; m_ovf = 1; end
                    end else if (d != 0) begin
                        m_se = 1; m_errs++;
                        m_pos = m_pos - (m_pos % 16) + int'(cnt);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ext_count", int'(bus.ext_count), m_pos);
            chk("wrap_up",   int'(bus.wrap_up),   int'(m_wu));
            chk("wrap_dn",   int'(bus.wrap_dn),   int'(m_wd));
            chk("step_err",  int'(bus.step_err),  int'(m_se));
            chk("dir_err",   int'(bus.dir_err),   int'(m_de));
            chk("ext_ovf",   int'(bus.ext_ovf),   int'(m_ovf));
            chk("locked",    int'(bus.locked),    int'(m_locked));
            chk("err_count", int'(bus.err_count), (m_errs > 255) ? 255 : m_errs);
            chk("err_count2", int'(bus2.err_count), (m_errs > 3) ? 3 : m_errs);
        end
    end

    // Apply one cycle of inputs and return at the following falling edge
    task automatic step(input logic r, input logic rs, input logic v,
                        input logic [3:0] c, input logic d);
        reset = r; rsync = rs; vld = v; cnt = c; dr = d;
        @(negedge clk);
        $display("txn rst=%0b rsync=%0b valid=%0b cnt=%0d dir=%0b -> ext=%02h wu=%0b wd=%0b se=%0b de=%0b ovf=%0b err=%0d lock=%0b",
                 r, rs, v, c, d, bus.ext_count, bus.wrap_up, bus.wrap_dn, bus.step_err,
                 bus.dir_err, bus.ext_ovf, bus.err_count, bus.locked);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; rsync = 1'b0; vld = 1'b0; cnt = 4'd0; dr = 1'b0;
        @(negedge clk);
        // T1 reset
        step(1, 0, 0, 4'd0, 0);
        chk_en = 1'b1;
        step(1, 0, 0, 4'd0, 0);
        chk("t1_ext", int'(bus.ext_count), 0);
        chk("t1_err", int'(bus.err_count), 0);
        chk("t1_locked", int'(bus.locked), 0);
        chk("t1_pulses", int'({bus.wrap_up, bus.wrap_dn, bus.step_err, bus.dir_err}), 0);

        // T2 count up through a wrap
        for (int i = 0; i < 16; i++) step(0, 0, 1, 4'(i), 0);
        chk("t2_ext15", int'(bus.ext_count), 8'h0F);
        step(0, 0, 1, 4'd0, 0);
        chk("t2_wrap_up", int'(bus.wrap_up), 1);
        step(0, 0, 1, 4'd1, 0);
        chk("t2_wrap_up_clear", int'(bus.wrap_up), 0);
        chk("t2_ext", int'(bus.ext_count), 8'h11);
        chk("t2_locked", int'(bus.locked), 1);

        // valid=0 holds everything
        step(0, 0, 0, 4'd9, 1);
        chk("hold_ext", int'(bus.ext_count), 8'h11);

        // T3 count down through two wraps, the second underflows the epoch
        step(0, 0, 1, 4'd0, 1);
        chk("t3_ext10", int'(bus.ext_count), 8'h10);
        step(0, 0, 1, 4'd15, 1);
        chk("t3_wrap_dn", int'(bus.wrap_dn), 1);
        chk("t3_ext0f", int'(bus.ext_count), 8'h0F);
        chk("t3_no_ovf", int'(bus.ext_ovf), 0);
        for (int i = 14; i >= 0; i--) step(0, 0, 1, 4'(i), 1);
        step(0, 0, 1, 4'd15, 1);
        chk("t3_extff", int'(bus.ext_count), 8'hFF);
        chk("t3_ovf", int'(bus.ext_ovf), 1);

        // T4 illegal jump 5 -> 9
        for (int i = 0; i <= 5; i++) step(0, 0, 1, 4'(i), 0);
        chk("t4_ext05", int'(bus.ext_count), 8'h05);
        step(0, 0, 1, 4'd9, 0);
        chk("t4_step_err", int'(bus.step_err), 1);
        chk("t4_err", int'(bus.err_count), 1);
        chk("t4_ext", int'(bus.ext_count), 8'h09);

        // T5 direction mismatches and saturation on the narrow tally
        step(0, 0, 1, 4'd3, 0);
        step(0, 0, 1, 4'd4, 1);
        chk("t5_dir_err", int'(bus.dir_err), 1);
        chk("t5_ext", int'(bus.ext_count), 8'h04);
        chk("t5_err", int'(bus.err_count), 3);
        step(0, 0, 1, 4'd4, 1);
        chk("t5_hold_no_err", int'(bus.dir_err), 0);
        step(0, 0, 1, 4'd3, 0);
        step(0, 0, 1, 4'd4, 1);
        chk("t5_err5", int'(bus.err_count), 5);
        chk("t5_sat", int'(bus2.err_count), 3);

        // T6 resync then re-acquire at 15
        step(0, 1, 1, 4'd15, 0);
        chk("t6_locked", int'(bus.locked), 0);
        chk("t6_ext_hold", int'(bus.ext_count), 8'h04);
        step(0, 0, 1, 4'd15, 0);
        chk("t6_no_step_err", int'(bus.step_err), 0);
        chk("t6_ext", int'(bus.ext_count), 8'h0F);
        chk("t6_relock", int'(bus.locked), 1);
        chk("t6_err_hold", int'(bus.err_count), 5);

        // Reset during a would-be wrap wins
        step(1, 0, 1, 4'd0, 0);
        chk("rst_wrap", int'(bus.wrap_up), 0);
        chk("rst_ext", int'(bus.ext_count), 0);
        chk("rst_ovf", int'(bus.ext_ovf), 0);
        step(0, 0, 0, 4'd0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
